// File: rtl/encoder4x2_switch.sv
// Registered 4-to-2 one-hot encoder with zero-input hold and multi-hot error flag.
// A one-hot input gives its bit index with valid set. A multi-hot input gives the
// index of its highest set bit with err set. An all-zero input keeps the last
// index and clears both flags.
module encoder4x2_switch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [1:0] result,
  output logic       valid,
  output logic       err
);

  logic [1:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic       any_set;
  logic       multi_set;
  logic [1:0] high_idx;

  assign any_set   = |in;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_set = |(in & (in - 4'd1));

  // Priority search: the highest set bit wins, which is the only set bit for one-hot input.
  always_comb begin
    high_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (in[i]) high_idx = 2'(i);
    end
  end

  // Next-state decode: an all-zero input holds the index, any other input replaces it.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (any_set) begin
      result_d = high_idx;
      valid_d  = ~multi_set;
      err_d    = multi_set;
    end
  end

  // Output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 2'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_encoder4x2_switch.sv
// Directed bench for encoder4x2_switch. Inputs change 1 ns after a rising edge,
// and outputs are sampled 1 ns after the next rising edge.
module tb_encoder4x2_switch;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [1:0] result;
  logic       valid;
  logic       err;

  int checks;
  int fails;

  encoder4x2_switch dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .result (result),
    .valid  (valid),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in    = 4'b1000;
    #3; // before the first rising edge at t=5
    checks++;
    if ({result, valid, err} !== 4'b0000) begin
      $display("FAIL reset_async: got {result,valid,err}=%b want 0000", {result, valid, err});
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({result, valid, err} !== 4'b1110) begin
      $display("FAIL reset_release: got {result,valid,err}=%b want 1110", {result, valid, err});
      fails++;
    end
    $display("test_reset: in=1000 -> %b %b %b", result, valid, err);
  endtask

  task automatic test_walk();
    logic [3:0] codes [4];
    logic [3:0] want  [4];
    codes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    want  = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};
    for (int i = 0; i < 4; i++) begin
      in = codes[i];
      tick();
      checks++;
      if ({result, valid, err} !== want[i]) begin
        $display("FAIL walk_%0d: in=%b got %b want %b", i, codes[i], {result, valid, err}, want[i]);
        fails++;
      end
      $display("test_walk: in=%b -> %b %b %b", codes[i], result, valid, err);
    end
  endtask

  task automatic test_zero_hold();
    in = 4'b0100;
    tick();
    checks++;
    if ({result, valid, err} !== 4'b1010) begin
      $display("FAIL zero_hold_pre: got %b want 1010", {result, valid, err});
      fails++;
    end
    in = 4'b0000;
    tick();
    checks++;
    if ({result, valid, err} !== 4'b1000) begin
      $display("FAIL zero_hold: got %b want 1000", {result, valid, err});
      fails++;
    end
    tick(); // a second zero cycle keeps holding
    checks++;
    if ({result, valid, err} !== 4'b1000) begin
      $display("FAIL zero_hold_2: got %b want 1000", {result, valid, err});
      fails++;
    end
    $display("test_zero_hold: in=0000 -> %b %b %b", result, valid, err);
  endtask

  task automatic test_multi_hot();
    logic [3:0] codes [3];
    logic [3:0] want  [3];
    codes = '{4'b0110, 4'b1111, 4'b0001};
    want  = '{4'b1001, 4'b1101, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      in = codes[i];
      tick();
      checks++;
      if ({result, valid, err} !== want[i]) begin
        $display("FAIL multi_%0d: in=%b got %b want %b", i, codes[i], {result, valid, err}, want[i]);
        fails++;
      end
      $display("test_multi_hot: in=%b -> %b %b %b", codes[i], result, valid, err);
    end
  endtask

  task automatic test_reset_mid();
    in = 4'b0010;
    tick();
    in = 4'b0100;
    tick();
    checks++;
    if ({result, valid, err} !== 4'b1010) begin
      $display("FAIL mid_pre: got %b want 1010", {result, valid, err});
      fails++;
    end
    #2;
    rst_n = 1'b0; // between edges
    #1;
    checks++;
    if ({result, valid, err} !== 4'b0000) begin
      $display("FAIL mid_async_clear: got %b want 0000", {result, valid, err});
      fails++;
    end
    in = 4'b1000;
    tick(); // edge during reset must be ignored
    checks++;
    if ({result, valid, err} !== 4'b0000) begin
      $display("FAIL mid_held_in_reset: got %b want 0000", {result, valid, err});
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    in    = 4'b0000;
    tick(); // zero after reset keeps result at 00
    checks++;
    if ({result, valid, err} !== 4'b0000) begin
      $display("FAIL mid_zero_after_reset: got %b want 0000", {result, valid, err});
      fails++;
    end
    in = 4'b1000;
    tick();
    checks++;
    if ({result, valid, err} !== 4'b1110) begin
      $display("FAIL mid_resume: got %b want 1110", {result, valid, err});
      fails++;
    end
    $display("test_reset_mid: resume in=1000 -> %b %b %b", result, valid, err);
  endtask

  task automatic test_exhaustive();
    logic [3:0] order [16];
    logic [3:0] tmp;
    logic [1:0] exp_res;
    logic       exp_valid;
    logic       exp_err;
    int         nbits;
    int         j;
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    in = 4'b0001;
    tick();
    exp_res = 2'd0;
    for (int i = 0; i < 16; i++) begin
      in = order[i];
      tick();
      nbits = 0;
      for (int b = 0; b < 4; b++) nbits += int'(order[i][b]);
      if (order[i][3])      exp_res = 2'd3;
      else if (order[i][2]) exp_res = 2'd2;
      else if (order[i][1]) exp_res = 2'd1;
      else if (order[i][0]) exp_res = 2'd0;
      exp_valid = (nbits == 1);
      exp_err   = (nbits > 1);
      checks++;
      if ({result, valid, err} !== {exp_res, exp_valid, exp_err}) begin
        $display("FAIL exh_%b: got %b want %b", order[i], {result, valid, err}, {exp_res, exp_valid, exp_err});
        fails++;
      end
      checks++;
      if ((valid & err) !== 1'b0) begin
        $display("FAIL exh_mutex_%b: valid=%b err=%b want not both 1", order[i], valid, err);
        fails++;
      end
      $display("test_exhaustive: in=%b -> %b %b %b", order[i], result, valid, err);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    in     = 4'b0000;
    test_reset();
    test_walk();
    test_zero_hold();
    test_multi_hot();
    test_reset_mid();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
